// File: rtl/dmadd_pkg.sv
// rtl/dmadd_pkg.sv - insn codes, FSM states and the add helper (wrapping, or saturating under DMADD_SAT_EN)
package dmadd_pkg;

  localparam logic [1:0] INSN_MIN  = 2'b00;
  localparam logic [1:0] INSN_MAX  = 2'b01;
  localparam logic [1:0] INSN_MADD = 2'b10;
  localparam logic [1:0] INSN_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Add two w-bit unsigned values (w <= 31); wraps by default, clamps at 2^w-1 when saturating.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
`ifdef DMADD_SAT_EN
    if (sum > lim) sum = lim;
`endif
    return sum[31:0] & lim[31:0];
  endfunction

endpackage

// File: rtl/dmadd_scan_if.sv
// rtl/dmadd_scan_if.sv - load/run command and busy/done/result bundle for dmadd_scan
interface dmadd_scan_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 12
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] data;
  logic [1:0]        insn;
  logic              load;
  logic              run;
  logic              busy;
  logic              done;
  logic              found;
  logic [ACC_W-1:0]  out;

  modport master (output index, data, insn, load, run,
                  input  busy, done, found, out);
  modport slave  (input  index, data, insn, load, run,
                  output busy, done, found, out);
endinterface

// File: rtl/dmadd_mem.sv
// rtl/dmadd_mem.sv - DEPTH x ACC_W accumulator register file with increment, clear-all and async read
module dmadd_mem
  import dmadd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACC_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [ACC_W-1:0]         wr_inc,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ACC_W-1:0]         rd_data
);

  logic [ACC_W-1:0] mem [DEPTH];
  logic [ACC_W-1:0] wr_val;

  // Read-modify-write value for the addressed entry.
  always_comb begin
    wr_val = ACC_W'(acc_add(32'(mem[wr_idx]), 32'(wr_inc), ACC_W));
  end

  // Scan pointer read is combinational so the FSM can decide in the same cycle.
  always_comb begin
    rd_data = mem[rd_idx];
  end

  // Entries clear on reset or clear-all, otherwise accumulate on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_val;
    end
  end

endmodule

// File: rtl/dmadd_scan.sv
// rtl/dmadd_scan.sv - MIN/MAX index finder and MADD scan engine; DMADD_SAT_EN makes arithmetic saturate
module dmadd_scan
  import dmadd_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 12
) (
  input logic          clk,
  input logic          rst_n,
  dmadd_scan_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] P_TOP = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] p;
  logic [1:0]       mode;
  logic [ACC_W-1:0] delta;
  logic [ACC_W-1:0] total;
  logic [ACC_W-1:0] rd;
  logic [ACC_W-1:0] delta_nxt;
  logic [ACC_W-1:0] total_nxt;
  logic [IDX_W-1:0] last_p;
  logic             mem_wr;
  logic             mem_clr;
  logic [ACC_W-1:0] mem_inc;

  // Loads only land in IDLE; CLEAR wipes everything, other modes accumulate.
  always_comb begin
    mem_clr = (state == S_IDLE) && bus.load && (bus.insn == INSN_CLR);
    mem_wr  = (state == S_IDLE) && bus.load && (bus.insn != INSN_CLR);
    mem_inc = (bus.insn == INSN_MADD) ? ACC_W'(bus.data) : ACC_W'(1);
  end

  dmadd_mem #(.DEPTH(DEPTH), .ACC_W(ACC_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mem_clr),
    .wr_en   (mem_wr),
    .wr_idx  (bus.index),
    .wr_inc  (mem_inc),
    .rd_idx  (p),
    .rd_data (rd)
  );

  // MADD step: running delta picks up mem[p], total picks up the updated delta.
  always_comb begin
    delta_nxt = ACC_W'(acc_add(32'(delta), 32'(rd), ACC_W));
    total_nxt = ACC_W'(acc_add(32'(total), 32'(delta_nxt), ACC_W));
    last_p    = (mode == INSN_MIN) ? P_TOP : '0;
  end

  // Control FSM with registered busy/done/found/out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p     <= '0;
      mode  <= INSN_MIN;
      delta <= '0;
      total <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.found <= 1'b0;
      bus.out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.run && !bus.load && bus.insn != INSN_CLR) begin
            state     <= S_SCAN;
            mode      <= bus.insn;
            p         <= (bus.insn == INSN_MIN) ? '0 : P_TOP;
            delta     <= '0;
            total     <= '0;
            bus.busy  <= 1'b1;
            bus.found <= 1'b0;
            bus.out   <= '0;
          end
        end
        S_SCAN: begin
          if (mode == INSN_MADD) begin
            delta <= delta_nxt;
            total <= total_nxt;
            if (p == last_p) begin
              state    <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.out  <= total_nxt;
            end else begin
              p <= p - 1'b1;
            end
          end else if (rd != '0) begin
            state     <= S_DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.found <= 1'b1;
            bus.out   <= ACC_W'(p);
          end else if (p == last_p) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            p <= (mode == INSN_MIN) ? p + 1'b1 : p - 1'b1;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmadd_scan.sv
// tb/tb_dmadd_scan.sv - directed self-checking bench for dmadd_scan
module tb_dmadd_scan;
  import dmadd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   lat;
  logic b0;

  dmadd_scan_if bus ();

  dmadd_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] idx, input logic [3:0] dat, input logic [1:0] ins);
    @(negedge clk);
    bus.index = idx;
    bus.data  = dat;
    bus.insn  = ins;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Latency counts cycles from the run cycle to the cycle done is high.
  task automatic run_scan(input logic [1:0] ins, output int cnt, output logic busy0);
    @(negedge clk);
    bus.insn = ins;
    bus.run  = 1'b1;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    bus.run = 1'b0;
    busy0 = bus.busy;
    while (!bus.done && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic chk_result(input string tag, input int exp_lat, input logic exp_found,
                            input logic [11:0] exp_out);
    run_scan(bus.insn, lat, b0);
    chk({tag, "_busy_start"}, 32'(b0), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_found"}, 32'(bus.found), 32'(exp_found));
    chk({tag, "_out"}, 32'(bus.out), 32'(exp_out));
  endtask

  initial begin
    bus.index = '0;
    bus.data  = '0;
    bus.insn  = INSN_MIN;
    bus.load  = 1'b0;
    bus.run   = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_found", 32'(bus.found), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MIN hit at index 5: six entries visited.
    do_load(4'd5, 4'd0, INSN_MIN);
    do_load(4'd9, 4'd0, INSN_MIN);
    bus.insn = INSN_MIN;
    chk_result("min", 7, 1'b1, 12'd5);
    @(negedge clk);
    chk("min_done_pulse", 32'(bus.done), 32'd0);
    chk("min_out_hold", 32'(bus.out), 32'd5);

    // MAX from the top: 15..9 visited.
    bus.insn = INSN_MAX;
    chk_result("max", 8, 1'b1, 12'd9);

    // Load and run together: load wins, no scan starts.
    @(negedge clk);
    bus.index = 4'd2;
    bus.insn  = INSN_MIN;
    bus.load  = 1'b1;
    bus.run   = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.run   = 1'b0;
    chk("ldrun_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("ldrun_busy2", 32'(bus.busy), 32'd0);
    bus.insn = INSN_MIN;
    chk_result("min2", 4, 1'b1, 12'd2);

    // Run with CLEAR code is ignored.
    @(negedge clk);
    bus.insn = INSN_CLR;
    bus.run  = 1'b1;
    @(negedge clk);
    bus.run  = 1'b0;
    @(negedge clk);
    chk("clr_run_busy", 32'(bus.busy), 32'd0);
    chk("clr_run_out", 32'(bus.out), 32'd2);

    // Clear then MIN scan misses everything.
    do_load(4'd0, 4'd0, INSN_CLR);
    bus.insn = INSN_MIN;
    chk_result("miss", 17, 1'b0, 12'd0);

    // MADD: 5*4 + 2*1 + 15*16 = 262.
    do_load(4'd3, 4'd5, INSN_MADD);
    do_load(4'd0, 4'd2, INSN_MADD);
    do_load(4'd15, 4'd15, INSN_MADD);
    bus.insn = INSN_MADD;
    chk_result("madd", 17, 1'b0, 12'd262);
    bus.insn = INSN_MADD;
    chk_result("madd_rpt", 17, 1'b0, 12'd262);

    // MADD overflow: mem[15]=270, 270*16=4320.
    do_load(4'd0, 4'd0, INSN_CLR);
    for (int i = 0; i < 18; i++) do_load(4'd15, 4'd15, INSN_MADD);
    bus.insn = INSN_MADD;
`ifdef DMADD_SAT_EN
    chk_result("madd_ovf", 17, 1'b0, 12'd4095);
`else
    chk_result("madd_ovf", 17, 1'b0, 12'd224);
`endif

    // Asynchronous reset in the middle of a MIN scan.
    do_load(4'd12, 4'd0, INSN_MIN);
    @(negedge clk);
    bus.insn = INSN_MIN;
    bus.run  = 1'b1;
    @(negedge clk);
    bus.run  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_out", 32'(bus.out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.insn = INSN_MIN;
    chk_result("post_rst", 17, 1'b0, 12'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
